// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - handshaked pipeline stage register with optional skid entry and stall counter
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;

    generate
        if (SKID != 0) begin : g_skid
            logic              s_valid;
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;
            logic              ready_q;

            // ready_q always tracks !s_valid so in_ready leaves straight from a flop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    s_data  <= '0;
                    ready_q <= 1'b1;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    ready_q <= 1'b1;
                end else if (s_valid && out_fire) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= s_ctrl;
                    m_data  <= s_data;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    ready_q <= 1'b1;
                end else if (in_fire && (!m_valid || out_ready)) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                    m_data  <= in_data;
                end else if (in_fire) begin
                    s_valid <= 1'b1;
                    s_ctrl  <= in_ctrl;
                    s_data  <= in_data;
                    ready_q <= 1'b0;
                end else if (out_fire) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end
            end

            assign in_ready = ready_q;
        end else begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end else if (in_fire) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                    m_data  <= in_data;
                end else if (out_fire) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end
            end

            assign in_ready = !m_valid | out_ready;
        end
    endgenerate

    // Flush deliberately leaves the counter alone; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid in skid and single-entry modes
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst_n;

    logic        f1, v1, ir1, ov1, r1;
    logic [31:0] d1, od1;
    logic [15:0] c1, oc1;
    logic [3:0]  so1;

    logic        f0, v0, ir0, ov0, r0;
    logic [31:0] d0, od0;
    logic [15:0] c0, oc0;
    logic [15:0] so0;

    int          checks;
    int          errors;
    logic [47:0] sbq [2][$];
    int          mcnt [2];
    int          outcnt [2];
    bit          seen_ff;
    bit          done;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(f1),
        .in_valid(v1), .in_ready(ir1), .in_data(d1), .in_ctrl(c1),
        .out_valid(ov1), .out_ready(r1), .out_data(od1), .out_ctrl(oc1),
        .stall_cnt(so1)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_single (
        .clk(clk), .rst_n(rst_n), .flush(f0),
        .in_valid(v0), .in_ready(ir0), .in_data(d0), .in_ctrl(c0),
        .out_valid(ov0), .out_ready(r0), .out_data(od0), .out_ctrl(oc0),
        .stall_cnt(so0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int id, input logic ov, input logic ordy, input logic [31:0] od,
                       input logic [15:0] oc, input logic iv, input logic ir,
                       input logic [31:0] idt, input logic [15:0] ic, input logic fl,
                       input logic [15:0] so);
        int          n;
        int          cmax;
        logic        exp_ir;
        logic [47:0] e;
        n      = sbq[id].size();
        cmax   = (id == 1) ? 15 : 65535;
        exp_ir = (id == 1) ? (n < 2) : ((n == 0) || ordy);
        check($sformatf("u%0d_out_valid", id), 64'(ov), 64'(n != 0));
        if (n == 0) check($sformatf("u%0d_bubble_ctrl", id), 64'(oc), 64'h0);
        check($sformatf("u%0d_in_ready", id), 64'(ir), 64'(exp_ir));
        check($sformatf("u%0d_stall_cnt", id), 64'(so), 64'(mcnt[id]));
        if (ov && oc == 16'h00FF) seen_ff = 1'b1;
        if (n != 0 && !ordy && mcnt[id] < cmax) mcnt[id]++;
        if (n != 0 && ordy) begin
            e = sbq[id].pop_front();
            outcnt[id]++;
            check($sformatf("u%0d_out_data", id), 64'(od), 64'(e[31:0]));
            check($sformatf("u%0d_out_ctrl", id), 64'(oc), 64'(e[47:32]));
        end
        if (fl) sbq[id].delete();
        else if (iv && exp_ir) sbq[id].push_back({ic, idt});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq[0].delete();
            sbq[1].delete();
            mcnt[0] = 0;
            mcnt[1] = 0;
        end else begin
            mon(1, ov1, r1, od1, oc1, v1, ir1, d1, c1, f1, {12'h0, so1});
            mon(0, ov0, r0, od0, oc0, v0, ir0, d0, c0, f0, so0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; f0 = 1'b0; f1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'({ov1, ov0}), 64'h0);
        check("rst_out_ctrl", 64'({oc1, oc0}), 64'h0);
        check("rst_out_data", 64'({od1, od0}), 64'h0);
        check("rst_in_ready", 64'({ir1, ir0}), 64'h3);
        check("rst_stall_cnt", 64'({so1, so0}), 64'h0);
        outcnt[0] = 0;
        outcnt[1] = 0;
        seen_ff   = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic send(input int id, input logic [31:0] d, input logic [15:0] c);
        logic rdy;
        if (id == 1) begin v1 = 1'b1; d1 = d; c1 = c; end
        else         begin v0 = 1'b1; d0 = d; c0 = c; end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            rdy = (id == 1) ? ir1 : ir0;
            @(posedge clk);
            #1;
            if (rdy) begin
                if (id == 1) v1 = 1'b0;
                else         v0 = 1'b0;
                return;
            end
        end
        check("send_timeout", 64'h0, 64'h1);
        if (id == 1) v1 = 1'b0;
        else         v0 = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        checks = 0; errors = 0;
        d0 = '0; d1 = '0; c0 = '0; c1 = '0;
        done = 1'b0;
        do_reset();

        // back-to-back streams in both modes
        for (int i = 0; i < 8; i++) send(1, 32'h100 + i, 16'(i + 1));
        for (int i = 0; i < 8; i++) send(0, 32'h100 + i, 16'(i + 1));
        repeat (3) step();
        check("stream_count_skid", 64'(outcnt[1]), 64'd8);
        check("stream_count_single", 64'(outcnt[0]), 64'd8);

        // skid fill: A and B absorbed, C refused while held
        do_reset();
        r1 = 1'b0;
        send(1, 32'h10, 16'h1);
        send(1, 32'h20, 16'h2);
        v1 = 1'b1; d1 = 32'h30; c1 = 16'h3;
        @(negedge clk);
        check("skid_full_in_ready", 64'(ir1), 64'h0);
        repeat (3) step();
        check("skid_held_stall_cnt", 64'(so1), 64'd4);
        r1 = 1'b1;
        send(1, 32'h30, 16'h3);
        repeat (3) step();
        check("skid_drain_count", 64'(outcnt[1]), 64'd3);
        check("skid_stall_final", 64'(so1), 64'd4);

        // flush with both entries full and a 0x00FF entry offered
        do_reset();
        r1 = 1'b0;
        send(1, 32'h40, 16'h11);
        send(1, 32'h50, 16'h22);
        v1 = 1'b1; d1 = 32'h77; c1 = 16'h00FF; f1 = 1'b1;
        step();
        f1 = 1'b0; v1 = 1'b0;
        check("flush_out_valid", 64'(ov1), 64'h0);
        check("flush_out_ctrl", 64'(oc1), 64'h0);
        check("flush_in_ready", 64'(ir1), 64'h1);
        r1 = 1'b1;
        send(1, 32'h80, 16'h44);
        // single mode: flush drops a firing input while the outgoing entry completes
        send(0, 32'h60, 16'h33);
        v0 = 1'b1; d0 = 32'h99; c0 = 16'h00FF; f0 = 1'b1;
        step();
        f0 = 1'b0; v0 = 1'b0;
        check("flush0_out_valid", 64'(ov0), 64'h0);
        check("flush0_in_ready", 64'(ir0), 64'h1);
        repeat (3) step();
        check("flush_no_ff", 64'(seen_ff), 64'h0);
        check("flush_counts", 64'({outcnt[1][7:0], outcnt[0][7:0]}), 64'h0101);

        // single mode: in_ready mirrors out_ready combinationally when full
        do_reset();
        r0 = 1'b0;
        send(0, 32'h70, 16'h5);
        #1 check("mirror_ready_0a", 64'(ir0), 64'h0);
        r0 = 1'b1;
        #1 check("mirror_ready_1", 64'(ir0), 64'h1);
        r0 = 1'b0;
        #1 check("mirror_ready_0b", 64'(ir0), 64'h0);
        r0 = 1'b1;
        repeat (2) step();

        // single mode: 16 entries under random stalls
        do_reset();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(0, $urandom, 16'($urandom_range(1, 16'hFFFE)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    r0 = 1'($urandom);
                end
            end
        join
        r0 = 1'b1;
        repeat (4) step();
        check("random_count", 64'(outcnt[0]), 64'd16);
        check("random_empty", 64'(sbq[0].size()), 64'd0);

        // saturation with a 4-bit counter
        do_reset();
        r1 = 1'b0;
        send(1, 32'hA5, 16'h7);
        repeat (20) step();
        check("sat_value", 64'(so1), 64'd15);
        f1 = 1'b1;
        step();
        f1 = 1'b0;
        step();
        check("sat_after_flush", 64'(so1), 64'd15);
        check("sat_flush_valid", 64'(ov1), 64'h0);

        // asynchronous reset between edges with two entries held
        send(1, 32'h1234, 16'h9);
        send(1, 32'h5678, 16'hA);
        check("async_pre_valid", 64'(ov1), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(ov1), 64'h0);
        check("async_out_ctrl", 64'(oc1), 64'h0);
        check("async_out_data", 64'(od1), 64'h0);
        check("async_stall_cnt", 64'(so1), 64'h0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
